// File: rtl/ltc2308_emulator.sv
// LTC2308 ADC responder: answers the controller's CONVST/SCK/SDI handshake
// with 12-bit codes derived from a parallel bank of eight channel values.
module ltc2308_emulator #(
  parameter int unsigned CONV_CYCLES = 80,
  parameter int unsigned DATA_BITS   = 12,
  parameter int unsigned CFG_BITS    = 6
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic                     convst,
  input  logic                     sck,
  input  logic                     sdi,
  output logic                     sdo,
  input  logic [8*DATA_BITS-1:0]   ch_data,
  output logic                     busy,
  output logic [CFG_BITS-1:0]      last_cfg,
  output logic [15:0]              frame_count,
  output logic                     protocol_err
);

  localparam int unsigned CNT_W     = $clog2(CONV_CYCLES + 1);
  localparam int unsigned BIT_W     = $clog2(DATA_BITS);
  localparam int unsigned CFG_CNT_W = $clog2(CFG_BITS + 1);
  localparam logic [CFG_BITS-1:0] CFG_RESET = 6'b100010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_READY,
    S_SHIFT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]            r_convst_sync;
  logic [2:0]            r_sck_sync;
  logic [1:0]            r_sdi_sync;
  logic [CNT_W-1:0]      r_conv_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [CFG_CNT_W-1:0]  r_cfg_cnt;
  logic [CFG_BITS-1:0]   r_cfg_sr;
  logic [CFG_BITS-1:0]   r_cfg;
  logic [DATA_BITS-1:0]  r_result;
  logic                  r_sdo;
  logic                  r_busy;
  logic [15:0]           r_frame_count;
  logic                  r_protocol_err;

  logic w_convst_rise;
  logic w_convst_lvl;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_sdi;
  logic w_conv_done;
  logic w_last_bit;
  logic w_cfg_full;
  logic w_frame_done;
  logic w_abort;
  logic w_start;
  logic w_commit;
  logic w_err;

  logic                  w_sd, w_os, w_s1, w_s0, w_uni;
  logic [2:0]            w_sel;
  logic [DATA_BITS-1:0]  w_ch [8];
  logic [DATA_BITS-1:0]  w_ch_a;
  logic [DATA_BITS-1:0]  w_ch_b;
  logic signed [DATA_BITS:0] w_diff;
  logic [DATA_BITS-1:0]  w_code;

  // Two-flop synchronizers; the third flop on convst/sck provides edge detection.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_convst_sync <= '0;
      r_sck_sync    <= '0;
      r_sdi_sync    <= '0;
    end else begin
      r_convst_sync <= {r_convst_sync[1:0], convst};
      r_sck_sync    <= {r_sck_sync[1:0], sck};
      r_sdi_sync    <= {r_sdi_sync[0], sdi};
    end
  end

  assign w_convst_rise = r_convst_sync[1] & ~r_convst_sync[2];
  assign w_convst_lvl  = r_convst_sync[1];
  assign w_sck_rise    = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall    = ~r_sck_sync[1] & r_sck_sync[2];
  assign w_sdi         = r_sdi_sync[1];

  assign w_conv_done  = (r_conv_cnt <= CNT_W'(1));
  assign w_last_bit   = (r_bit_cnt == BIT_W'(DATA_BITS - 1));
  assign w_cfg_full   = (r_cfg_cnt == CFG_CNT_W'(CFG_BITS));
  assign w_frame_done = (r_state == S_SHIFT) && !w_convst_rise && w_sck_fall && w_last_bit;
  assign w_abort      = (r_state == S_SHIFT) && w_convst_rise;
  assign w_start      = ((r_state == S_IDLE) && w_convst_rise) || w_abort;
  // A complete config word is committed whether the frame ends normally or is
  // aborted; the restarted conversion then already uses it.
  assign w_commit     = (w_frame_done || w_abort) && w_cfg_full;
  assign w_err        = ((r_state == S_CONVERT) && (w_convst_rise || w_sck_rise || w_sck_fall))
                        || w_abort;

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_convst_rise) w_state_nxt = S_CONVERT;
      S_CONVERT: if (w_conv_done)   w_state_nxt = S_READY;
      S_READY:   if (!w_convst_lvl) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (w_abort)           w_state_nxt = S_CONVERT;
        else if (w_frame_done) w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Result code for the config that will be in force at conversion start.
  always_comb begin
    w_sd  = w_commit ? r_cfg_sr[5] : r_cfg[5];
    w_os  = w_commit ? r_cfg_sr[4] : r_cfg[4];
    w_s1  = w_commit ? r_cfg_sr[3] : r_cfg[3];
    w_s0  = w_commit ? r_cfg_sr[2] : r_cfg[2];
    w_uni = w_commit ? r_cfg_sr[1] : r_cfg[1];
    for (int unsigned n = 0; n < 8; n++) begin
      w_ch[n] = ch_data[n*DATA_BITS +: DATA_BITS];
    end
    w_sel  = {w_s1, w_s0, w_os};
    w_ch_a = w_ch[w_sel];
    w_ch_b = w_ch[w_sel ^ 3'b001];
    w_diff = $signed({1'b0, w_ch_a}) - $signed({1'b0, w_ch_b});
    w_code = '0;
    if (w_sd) begin
      w_code = w_uni ? w_ch_a : {~w_ch_a[DATA_BITS-1], w_ch_a[DATA_BITS-2:0]};
    end else if (w_uni) begin
      w_code = w_diff[DATA_BITS] ? '0 : w_diff[DATA_BITS-1:0];
    end else if (w_diff[DATA_BITS] != w_diff[DATA_BITS-1]) begin
      // Sign and top bit disagree: saturate to the signed range.
      w_code = {w_diff[DATA_BITS], {(DATA_BITS-1){~w_diff[DATA_BITS]}}};
    end else begin
      w_code = w_diff[DATA_BITS-1:0];
    end
  end

  // Conversion timer, serial shifting, config capture and status outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_conv_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_cfg_cnt      <= '0;
      r_cfg_sr       <= '0;
      r_cfg          <= CFG_RESET;
      r_result       <= '0;
      r_sdo          <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_count  <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      r_protocol_err <= w_err;
      if (w_commit) r_cfg <= r_cfg_sr;
      if (w_start) begin
        r_result   <= w_code;
        r_conv_cnt <= CNT_W'(CONV_CYCLES);
        r_busy     <= 1'b1;
        r_sdo      <= 1'b0;
      end else begin
        case (r_state)
          S_CONVERT: begin
            r_sdo <= 1'b0;
            if (w_conv_done) begin
              r_busy     <= 1'b0;
              r_conv_cnt <= '0;
            end else begin
              r_conv_cnt <= r_conv_cnt - CNT_W'(1);
            end
          end
          S_READY: begin
            if (!w_convst_lvl) begin
              r_sdo     <= r_result[DATA_BITS-1];
              r_bit_cnt <= '0;
              r_cfg_cnt <= '0;
            end
          end
          S_SHIFT: begin
            if (w_sck_rise && (r_cfg_cnt < CFG_CNT_W'(CFG_BITS))) begin
              r_cfg_sr  <= {r_cfg_sr[CFG_BITS-2:0], w_sdi};
              r_cfg_cnt <= r_cfg_cnt + CFG_CNT_W'(1);
            end
            if (w_sck_fall) begin
              if (w_last_bit) begin
                r_sdo         <= 1'b0;
                r_frame_count <= r_frame_count + 16'd1;
              end else begin
                r_sdo     <= r_result[DATA_BITS-2];
                r_result  <= r_result << 1;
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
              end
            end
          end
          default: r_sdo <= 1'b0;
        endcase
      end
    end
  end

  assign sdo          = r_sdo;
  assign busy         = r_busy;
  assign last_cfg     = r_cfg;
  assign frame_count  = r_frame_count;
  assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_ltc2308_emulator.sv
// Directed bench for ltc2308_emulator acting as the ADC controller.
module tb_ltc2308_emulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        convst;
  logic        sck;
  logic        sdi;
  logic        sdo;
  logic [95:0] ch_data;
  logic        busy;
  logic [5:0]  last_cfg;
  logic [15:0] frame_count;
  logic        protocol_err;

  int n_cmp = 0;
  int n_err = 0;
  int exp_fc = 0;

  always #10 clk = ~clk;

  ltc2308_emulator #(
    .CONV_CYCLES(80),
    .DATA_BITS  (12),
    .CFG_BITS   (6)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .convst       (convst),
    .sck          (sck),
    .sdi          (sdi),
    .sdo          (sdo),
    .ch_data      (ch_data),
    .busy         (busy),
    .last_cfg     (last_cfg),
    .frame_count  (frame_count),
    .protocol_err (protocol_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int n, input logic [11:0] v);
    ch_data[n*12 +: 12] = v;
  endtask

  // CONVST pulse and wait for busy to go high then low; optionally pokes sck
  // mid-conversion. Counts busy-high cycles and protocol_err pulses.
  task automatic convert(input bit poke, output int hi, output int nerr, output bit done);
    bit seen = 0;
    hi = 0; nerr = 0; done = 0;
    convst = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 3) convst = 1'b0;
      if (poke && k == 10) sck = 1'b1;
      if (poke && k == 20) sck = 1'b0;
      if (protocol_err) nerr++;
      if (busy) begin
        hi++;
        seen = 1;
      end else if (seen) begin
        done = 1;
        break;
      end
    end
    convst = 1'b0;
  endtask

  task automatic sck_bit(input logic b, output logic got);
    sdi = b;
    repeat (4) @(negedge clk);
    got = sdo;
    sck = 1'b1;
    repeat (5) @(negedge clk);
    sck = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic frame(input logic [5:0] cfg, output logic [11:0] data);
    logic b;
    data = '0;
    for (int i = 0; i < 12; i++) begin
      sck_bit((i < 6) ? cfg[5-i] : 1'b0, b);
      data = {data[10:0], b};
    end
  endtask

  task automatic run_frame(input string tag, input logic [5:0] cfg, input logic [11:0] exp_code);
    int hi, ne;
    bit done;
    logic [11:0] d;
    convert(1'b0, hi, ne, done);
    check({tag, "_conv_done"}, 32'(done), 32'd1);
    frame(cfg, d);
    exp_fc++;
    check({tag, "_code"}, 32'(d), 32'(exp_code));
    check({tag, "_fc"}, 32'(frame_count), 32'(exp_fc));
    check({tag, "_cfg"}, 32'(last_cfg), 32'(cfg));
  endtask

  initial begin
    int hi, ne;
    bit done, err_seen, busy_seen;
    logic [11:0] d;
    logic b;

    rst_n = 1'b0; convst = 1'b0; sck = 1'b0; sdi = 1'b0; ch_data = '0;
    repeat (3) @(negedge clk);
    check("rst_sdo",  32'(sdo), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fc",   32'(frame_count), 32'd0);
    check("rst_err",  32'(protocol_err), 32'd0);
    check("rst_cfg",  32'(last_cfg), 32'h22);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1: CH0 unipolar, busy width, config 110010 sent for next frame.
    set_ch(0, 12'hA5C);
    set_ch(1, 12'h123);
    convert(1'b0, hi, ne, done);
    check("f1_conv_done", 32'(done), 32'd1);
    check("f1_busy_cycles", 32'(hi), 32'd80);
    check("f1_no_err", 32'(ne), 32'd0);
    frame(6'b110010, d);
    exp_fc++;
    check("f1_code", 32'(d), 32'hA5C);
    check("f1_fc", 32'(frame_count), 32'(exp_fc));
    check("f1_cfg", 32'(last_cfg), 32'h32);

    run_frame("f2_ch1", 6'b100000, 12'h123);
    set_ch(0, 12'h000);
    run_frame("f3_bip_se", 6'b000010, 12'h800);
    set_ch(0, 12'd100);
    set_ch(1, 12'd300);
    run_frame("f4_diff_uni_neg", 6'b000000, 12'h000);
    run_frame("f5_diff_bip", 6'b010010, 12'hF38);
    run_frame("f6_diff_uni_pos", 6'b000000, 12'h0C8);
    set_ch(0, 12'hFFF);
    set_ch(1, 12'h000);
    run_frame("f7_diff_bip_sat", 6'b100010, 12'h7FF);

    // sck edges while converting.
    convert(1'b1, hi, ne, done);
    check("cv_conv_done", 32'(done), 32'd1);
    check("cv_err_pulses", 32'(ne), 32'd2);
    frame(6'b100010, d);
    exp_fc++;
    check("cv_code", 32'(d), 32'hFFF);
    check("cv_fc", 32'(frame_count), 32'(exp_fc));

    // Abort after three sck in SHIFT.
    set_ch(0, 12'h3C5);
    convert(1'b0, hi, ne, done);
    check("ab_conv_done", 32'(done), 32'd1);
    sck_bit(1'b1, b);
    sck_bit(1'b1, b);
    sck_bit(1'b0, b);
    err_seen = 0; busy_seen = 0;
    convst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 3) convst = 1'b0;
      if (protocol_err) err_seen = 1;
      if (busy) busy_seen = 1;
    end
    check("ab_err", 32'(err_seen), 32'd1);
    check("ab_busy", 32'(busy_seen), 32'd1);
    check("ab_cfg", 32'(last_cfg), 32'h22);
    check("ab_fc", 32'(frame_count), 32'(exp_fc));
    done = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    check("ab_busy_fall", 32'(done), 32'd1);
    frame(6'b110010, d);
    exp_fc++;
    check("ab_code", 32'(d), 32'h3C5);
    check("ab_fc_after", 32'(frame_count), 32'(exp_fc));

    // Reset mid-SHIFT while sdo is high and last_cfg differs from reset.
    set_ch(0, 12'hFFF);
    set_ch(1, 12'hFFF);
    convert(1'b0, hi, ne, done);
    check("rs_conv_done", 32'(done), 32'd1);
    for (int i = 0; i < 4; i++) sck_bit(1'b1, b);
    check("rs_pre_sdo", 32'(sdo), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rs_sdo",  32'(sdo), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_fc",   32'(frame_count), 32'd0);
    check("rs_cfg",  32'(last_cfg), 32'h22);
    check("rs_err",  32'(protocol_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_fc = 0;
    run_frame("post_rst", 6'b100010, 12'hFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
